// File: rtl/acx_axi_req_arb.sv
// acx_axi_req_arb
// Round-robin, packet-locked arbiter that shares one request FIFO among
// NUM_REQ requesters. One requester is granted for a whole packet, and every
// pushed word is tagged {id, last, data} so the FIFO consumer can route
// responses.
//
// Handshake: a requester beat moves when i_req_valid[k] & o_req_ready[k].
// The FIFO side moves a word when o_push & i_accept. In XFER these are the
// same event for the granted requester g, because o_req_ready[g] = i_accept
// and o_push = i_req_valid[g]. A requester that raises valid holds valid and
// data stable until it sees ready.
//
// Ports
//   i_clk, i_rstn   clock, asynchronous active-low reset
//   i_req_valid     per-requester beat valid
//   i_req_last      per-requester last beat of packet
//   i_req_data      payloads, requester k at [k*WIDTH +: WIDTH]
//   o_req_ready     per-requester beat accepted
//   o_push          push strobe to the FIFO
//   o_push_data     pushed word {id, last, data}
//   i_accept        FIFO can take a word this cycle
//   o_grant         one-hot current grant, zero in ARB
//   o_busy          packet in progress (state XFER)
//   o_err_overlen   one-cycle pulse after a grant was force-released
module acx_axi_req_arb #(
   parameter int NUM_REQ   = 4,
   parameter int ID_W      = 2,
   parameter int WIDTH     = 8,
   parameter int MAX_BEATS = 16,
   parameter int BEAT_W    = 5
) (
   input  logic                     i_clk,
   input  logic                     i_rstn,
   input  logic [NUM_REQ-1:0]       i_req_valid,
   input  logic [NUM_REQ-1:0]       i_req_last,
   input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
   output logic [NUM_REQ-1:0]       o_req_ready,
   output logic                     o_push,
   output logic [ID_W+WIDTH:0]      o_push_data,
   input  logic                     i_accept,
   output logic [NUM_REQ-1:0]       o_grant,
   output logic                     o_busy,
   output logic                     o_err_overlen
);

   typedef enum logic {
      ARB  = 1'b0,
      XFER = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   gnt_id, gnt_nxt;
   logic [ID_W-1:0]   rr_ptr, rr_nxt;
   logic [BEAT_W-1:0] beat_cnt, cnt_nxt;
   logic              err_nxt;

   logic              win_found;
   logic [ID_W-1:0]   win_id;
   logic [ID_W:0]     cand;
   logic [ID_W-1:0]   rr_inc;

   logic              sel_valid;
   logic              sel_last;
   logic [WIDTH-1:0]  sel_data;
   logic              beat;
   logic              force_rel;

   // Round-robin search: walk upward from rr_ptr, wrapping at NUM_REQ.
   // cand carries one extra bit so the wrap works for any NUM_REQ.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
         if (cand >= (ID_W+1)'(NUM_REQ)) begin
            cand = cand - (ID_W+1)'(NUM_REQ);
         end
         if (!win_found && i_req_valid[cand[ID_W-1:0]]) begin
            win_found = 1'b1;
            win_id    = cand[ID_W-1:0];
         end
      end
   end

   // Signals of the currently granted requester.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt_id == ID_W'(k)) begin
            sel_valid = i_req_valid[k];
            sel_last  = i_req_last[k];
            sel_data  = i_req_data[k*WIDTH +: WIDTH];
         end
      end
   end

   assign rr_inc    = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
   assign beat      = (state == XFER) && sel_valid && i_accept;
   // The MAX_BEATS-th beat without last ends the grant; the rest of that
   // packet competes again as a fresh packet.
   assign force_rel = beat && !sel_last && (beat_cnt == BEAT_W'(MAX_BEATS-1));

   // Next-state logic
   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt_id;
      rr_nxt    = rr_ptr;
      cnt_nxt   = beat_cnt;
      err_nxt   = 1'b0;
      case (state)
         ARB: begin
            if (win_found) begin
               gnt_nxt   = win_id;
               cnt_nxt   = '0;
               state_nxt = XFER;
            end
         end
         XFER: begin
            if (beat) begin
               cnt_nxt = beat_cnt + BEAT_W'(1);
               err_nxt = force_rel;
               if (sel_last || force_rel) begin
                  state_nxt = ARB;
                  rr_nxt    = rr_inc;
               end
            end
         end
         default: state_nxt = ARB;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state         <= ARB;
         gnt_id        <= '0;
         rr_ptr        <= '0;
         beat_cnt      <= '0;
         o_err_overlen <= 1'b0;
      end else begin
         state         <= state_nxt;
         gnt_id        <= gnt_nxt;
         rr_ptr        <= rr_nxt;
         beat_cnt      <= cnt_nxt;
         o_err_overlen <= err_nxt;
      end
   end

   // Outputs are gated by state, so the asynchronous reset (state -> ARB)
   // clears them immediately.
   always_comb begin
      o_grant     = '0;
      o_req_ready = '0;
      o_push      = 1'b0;
      o_push_data = '0;
      if (state == XFER) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_id == ID_W'(k)) begin
               o_grant[k]     = 1'b1;
               o_req_ready[k] = i_accept;
            end
         end
         o_push      = sel_valid;
         o_push_data = {gnt_id, sel_last, sel_data};
      end
   end

   assign o_busy = (state == XFER);

endmodule
